// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_MUL = 4'd7;
   localparam logic [3:0] OP_DIV = 4'd8;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_EXEC = 3'd1;
   localparam logic [2:0] S_MUL  = 3'd2;
   localparam logic [2:0] S_DIV  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the accumulator side (master) and the ALU (slave).
// The rem signal exists only when ALU_SEQ_DIV_EN is defined.
interface alu_seq_if #(
   parameter int WIDTH = 16
) ();
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] acc;
   logic [3:0]       flags;
   logic             err;
`ifdef ALU_SEQ_DIV_EN
   logic [WIDTH-1:0] rem;
`endif

   modport master (
      output start, op, a, b,
      input  busy, done, acc, flags, err
`ifdef ALU_SEQ_DIV_EN
      , input rem
`endif
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, acc, flags, err
`ifdef ALU_SEQ_DIV_EN
      , output rem
`endif
   );
endinterface

// File: rtl/alu_shift_core.sv
// Iterative datapath shared by shift-add multiply and (with ALU_SEQ_DIV_EN) restoring divide.
// MUL: {part, shreg} is the 2*WIDTH product. DIV: shreg is the quotient, part the remainder.
module alu_shift_core #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
`ifdef ALU_SEQ_DIV_EN
   input  logic             div_mode_i,
`endif
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] part_o,
   output logic [WIDTH-1:0] shreg_o,
   output logic             last_o
);
   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   logic [WIDTH-1:0] part_q, part_d, shreg_q, shreg_d, opnd_q, opnd_d;
   logic [WIDTH-1:0] nxt_part, nxt_shreg;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   mul_sum;
`ifdef ALU_SEQ_DIV_EN
   logic             mode_q, mode_d;
   logic [WIDTH:0]   div_shift, div_diff;
`endif

   assign last_o  = (cnt_q == LAST);
   assign part_o  = part_q;
   assign shreg_o = shreg_q;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      part_d    = part_q;
      shreg_d   = shreg_q;
      opnd_d    = opnd_q;
      cnt_d     = cnt_q;
      mul_sum   = {1'b0, part_q} + (shreg_q[0] ? {1'b0, opnd_q} : '0);
      nxt_part  = mul_sum[WIDTH:1];
      nxt_shreg = {mul_sum[0], shreg_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
      mode_d    = mode_q;
      div_shift = {part_q, shreg_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      // A clear top bit of the difference means the trial subtraction fits: keep it, quotient bit 1.
      if (mode_q) begin
         nxt_part  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
         nxt_shreg = {shreg_q[WIDTH-2:0], ~div_diff[WIDTH]};
      end
`endif
      if (load_i) begin
         part_d  = '0;
         cnt_d   = '0;
         shreg_d = b_i;
         opnd_d  = a_i;
`ifdef ALU_SEQ_DIV_EN
         mode_d  = div_mode_i;
         if (div_mode_i) begin
            shreg_d = a_i;
            opnd_d  = b_i;
         end
`endif
      end else if (step_i && !last_o) begin
         cnt_d   = cnt_q + 1'b1;
         part_d  = nxt_part;
         shreg_d = nxt_shreg;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         part_q  <= '0;
         shreg_q <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
`ifdef ALU_SEQ_DIV_EN
         mode_q  <= 1'b0;
`endif
      end else begin
         part_q  <= part_d;
         shreg_q <= shreg_d;
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
`ifdef ALU_SEQ_DIV_EN
         mode_q  <= mode_d;
`endif
      end
   end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: FSM, single-cycle ops and result/flag registers; MUL/DIV via alu_shift_core.
// Define ALU_SEQ_DIV_EN to build the divider and the rem output.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input logic       clk,
   input logic       rst,
   alu_seq_if.slave  bus
);
   localparam int MSB = WIDTH - 1;

   logic [2:0]       state_q, state_d;
   logic [3:0]       op_q, op_d, flags_q, flags_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
   logic             err_q, err_d;
`ifdef ALU_SEQ_DIV_EN
   logic [WIDTH-1:0] rem_q, rem_d;
`endif

   logic [WIDTH:0]   add_sum;
   logic [WIDTH-1:0] ex_res, core_part, core_shreg;
   logic             ex_c, ex_v, ex_ill;
   logic             core_load, core_step, core_last, upd, c_sel, v_sel;

   alu_shift_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .rst        (rst),
      .load_i     (core_load),
      .step_i     (core_step),
`ifdef ALU_SEQ_DIV_EN
      .div_mode_i (bus.op == OP_DIV),
`endif
      .a_i        (bus.a),
      .b_i        (bus.b),
      .part_o     (core_part),
      .shreg_o    (core_shreg),
      .last_o     (core_last)
   );

   // Single-cycle ops; anything not handled here that lands in EXEC is illegal.
   always_comb begin
      add_sum = '0;
      ex_res  = a_q;
      ex_c    = 1'b0;
      ex_v    = 1'b0;
      ex_ill  = 1'b0;
      case (op_q)
         OP_ADD: begin
            add_sum = {1'b0, a_q} + {1'b0, b_q};
            ex_res  = add_sum[WIDTH-1:0];
            ex_c    = add_sum[WIDTH];
            ex_v    = (a_q[MSB] == b_q[MSB]) && (ex_res[MSB] != a_q[MSB]);
         end
         OP_SUB: begin
            add_sum = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
            ex_res  = add_sum[WIDTH-1:0];
            ex_c    = add_sum[WIDTH];
            ex_v    = (a_q[MSB] != b_q[MSB]) && (ex_res[MSB] != a_q[MSB]);
         end
         OP_AND: ex_res = a_q & b_q;
         OP_OR:  ex_res = a_q | b_q;
         OP_XOR: ex_res = a_q ^ b_q;
         OP_SHL: begin
            ex_res = {a_q[MSB-1:0], 1'b0};
            ex_c   = a_q[MSB];
         end
         OP_SHR: begin
            ex_res = {1'b0, a_q[MSB:1]};
            ex_c   = a_q[0];
         end
         default: ex_ill = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      flags_d   = flags_q;
      err_d     = err_q;
`ifdef ALU_SEQ_DIV_EN
      rem_d     = rem_q;
`endif
      core_load = 1'b0;
      core_step = 1'b0;
      upd       = 1'b0;
      c_sel     = 1'b0;
      v_sel     = 1'b0;
      case (state_q)
         S_IDLE: if (bus.start) begin
            op_d      = bus.op;
            a_d       = bus.a;
            b_d       = bus.b;
            err_d     = 1'b0;
            core_load = 1'b1;
            if (bus.op == OP_MUL) state_d = S_MUL;
`ifdef ALU_SEQ_DIV_EN
            else if (bus.op == OP_DIV) state_d = S_DIV;
`endif
            else state_d = S_EXEC;
         end
         S_EXEC: begin
            acc_d   = ex_res;
            c_sel   = ex_c;
            v_sel   = ex_v;
            err_d   = ex_ill;
            upd     = 1'b1;
            state_d = S_DONE;
         end
         S_MUL: begin
            core_step = 1'b1;
            if (core_last) begin
               acc_d   = core_shreg;
               c_sel   = |core_part;
               upd     = 1'b1;
               state_d = S_DONE;
            end
         end
`ifdef ALU_SEQ_DIV_EN
         S_DIV: begin
            core_step = 1'b1;
            if (core_last) begin
               acc_d   = core_shreg;
               rem_d   = core_part;
               err_d   = (b_q == '0);
               upd     = 1'b1;
               state_d = S_DONE;
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (upd) begin
         flags_d[FLAG_Z] = (acc_d == '0);
         flags_d[FLAG_N] = acc_d[MSB];
         flags_d[FLAG_C] = c_sel;
         flags_d[FLAG_V] = v_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         flags_q <= '0;
         err_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         rem_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         flags_q <= flags_d;
         err_q   <= err_d;
`ifdef ALU_SEQ_DIV_EN
         rem_q   <= rem_d;
`endif
      end
   end

   assign bus.busy  = (state_q == S_EXEC) || (state_q == S_MUL) || (state_q == S_DIV);
   assign bus.done  = (state_q == S_DONE);
   assign bus.acc   = acc_q;
   assign bus.flags = flags_q;
   assign bus.err   = err_q;
`ifdef ALU_SEQ_DIV_EN
   assign bus.rem   = rem_q;
`endif
endmodule
